// File: rtl/top_level_edge_engine.sv
// ---------------------------------------------------------------------------
// top_level_edge_engine
//
// Sobel edge detector that streams an RGB image out of word-addressed memory
// and writes an inverted edge-magnitude image back to memory. There is one
// pixel per 32-bit word. Dark output pixels mark strong edges on a white
// background.
//
// Parameters
//   IMG_WIDTH, IMG_HEIGHT : input image size in pixels
//   IN_BASE               : word address of input pixel (0,0)
//   OUT_BASE              : word address of output pixel (0,0)
//
// Ports
//   clk    : single clock; all state changes on the rising edge
//   n_rst  : asynchronous active-low reset
//   stop   : 1 = halt/abort and return to idle, 0 = run
//   hrdata : read data; channels [31:24],[23:16],[15:8]; [7:0] is ignored
//   hready : one-cycle transfer-complete pulse from memory
//   haddr  : word address of the current transfer
//   hwdata : write data; the result is replicated on [23:16],[15:8],[7:0]
//   hwrite : 1 = write transfer, 0 = read transfer
//   done   : high once every output pixel has been written
// ---------------------------------------------------------------------------
module top_level_edge_engine #(
    parameter int unsigned IMG_WIDTH  = 428,
    parameter int unsigned IMG_HEIGHT = 428,
    parameter int unsigned IN_BASE    = 1,
    parameter int unsigned OUT_BASE   = 1 + IMG_WIDTH * IMG_HEIGHT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        stop,
    input  logic [31:0] hrdata,
    input  logic        hready,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    output logic        hwrite,
    output logic        done
);

    localparam int unsigned OUT_W = IMG_WIDTH - 2;
    localparam int unsigned OUT_H = IMG_HEIGHT - 2;
    localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Output pixel position currently being assembled.
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    // Window-relative position of the pixel being read. At the start of a
    // row the whole 3x3 window is filled column by column (rd_c 0..2);
    // afterwards only the right column is refreshed, so rd_c stays at 2.
    logic [1:0] rd_r;
    logic [1:0] rd_c;

    // Gray-level window, win[row][col], col 0 is the leftmost column.
    logic [7:0] win [3][3];

    logic        win_last;
    logic        frame_last;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;

    logic [9:0]  gray_sum;
    logic [7:0]  gray;

    logic signed [11:0] gx;
    logic signed [11:0] gy;
    logic [11:0]        ax;
    logic [11:0]        ay;
    logic [12:0]        mag_sum;
    logic [7:0]         mag;
    logic [7:0]         pix;

    logic unused_bits;

    function automatic logic signed [11:0] ext8(input logic [7:0] v);
        return {4'b0000, v};
    endfunction

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    always_comb begin
        win_last   = (rd_r == 2'd2) && (rd_c == 2'd2);
        frame_last = (row == LAST_ROW) && (col == LAST_COL);
        rd_addr    = IN_BASE + (32'(row) + 32'(rd_r)) * IMG_WIDTH
                     + 32'(col) + 32'(rd_c);
        wr_addr    = OUT_BASE + 32'(row) * OUT_W + 32'(col);
    end

    // ------------------------------------------------------------------
    // Gray conversion of the incoming word: (ch2 + 2*ch1 + ch0) >> 2
    // ------------------------------------------------------------------
    always_comb begin
        gray_sum = {2'b00, hrdata[31:24]}
                 + {1'b0, hrdata[23:16], 1'b0}
                 + {2'b00, hrdata[15:8]};
        gray     = gray_sum[9:2];
    end

    assign unused_bits = ^{hrdata[7:0], gray_sum[1:0]};

    // ------------------------------------------------------------------
    // Sobel on the registered window. The window is stable for the whole
    // WRITE state, so the result can drive hwdata directly.
    // ------------------------------------------------------------------
    always_comb begin
        gx = (ext8(win[0][2]) + 12'sd2 * ext8(win[1][2]) + ext8(win[2][2]))
           - (ext8(win[0][0]) + 12'sd2 * ext8(win[1][0]) + ext8(win[2][0]));
        gy = (ext8(win[2][0]) + 12'sd2 * ext8(win[2][1]) + ext8(win[2][2]))
           - (ext8(win[0][0]) + 12'sd2 * ext8(win[0][1]) + ext8(win[0][2]));
        ax      = gx[11] ? -gx : gx;
        ay      = gy[11] ? -gy : gy;
        mag_sum = {1'b0, ax} + {1'b0, ay};
        mag     = (mag_sum > 13'd255) ? 8'hFF : mag_sum[7:0];
        pix     = 8'hFF - mag;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and bus outputs. The bus is driven only in READ and
    // WRITE; everywhere else it rests at zero.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        haddr      = '0;
        hwdata     = '0;
        hwrite     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                state_next = READ;
            end
            READ: begin
                haddr = rd_addr;
                if (hready && win_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                haddr  = wr_addr;
                hwdata = {8'h00, pix, pix, pix};
                hwrite = 1'b1;
                if (hready) begin
                    state_next = frame_last ? DONE : READ;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (stop) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Counters and window
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row  <= '0;
            col  <= '0;
            rd_r <= '0;
            rd_c <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (stop || (state == IDLE)) begin
            row  <= '0;
            col  <= '0;
            rd_r <= '0;
            rd_c <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if ((state == READ) && hready) begin
            if (col == '0) begin
                win[rd_r][rd_c] <= gray;
            end else if (rd_r == 2'd0) begin
                // First pixel of a new right column: slide the window left
                // and start filling column 2; rows 1 and 2 follow.
                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= gray;
            end else begin
                win[rd_r][2] <= gray;
            end
            if (rd_r == 2'd2) begin
                rd_r <= '0;
                if (rd_c != 2'd2) begin
                    rd_c <= rd_c + 2'd1;
                end
            end else begin
                rd_r <= rd_r + 2'd1;
            end
        end else if ((state == WRITE) && hready) begin
            if (col == LAST_COL) begin
                col  <= '0;
                rd_c <= '0;
                if (row != LAST_ROW) begin
                    row <= row + 1'b1;
                end
            end else begin
                col  <= col + 1'b1;
                rd_c <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_top_level_edge_engine.sv
module tb_top_level_edge_engine;

    localparam int W     = 9;
    localparam int H     = 6;
    localparam int IN_B  = 1;
    localparam int OUT_B = 1 + W * H;
    localparam int OW    = W - 2;
    localparam int OH    = H - 2;
    localparam int NWR   = OW * OH;
    localparam int NRD   = OH * (9 + 3 * (OW - 1));
    localparam int STEP  = W / 2;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        stop;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b0;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] img [W*H];
    logic [31:0] ref_data [NWR];

    int          mem_delay = 1;
    logic [31:0] last_addr = '0;
    logic        last_write = 1'b0;
    logic [31:0] cap_data = '0;
    int          cnt = 0;
    int          stab_err = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];

    top_level_edge_engine #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .IN_BASE   (IN_B)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .stop  (stop),
        .hrdata(hrdata),
        .hready(hready),
        .haddr (haddr),
        .hwdata(hwdata),
        .hwrite(hwrite),
        .done  (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int gray_of(input logic [31:0] w);
        return (int'(w[31:24]) + 2 * int'(w[23:16]) + int'(w[15:8])) / 4;
    endfunction

    function automatic logic [31:0] expect_pix(input int r, input int c);
        int g [3][3];
        int gx, gy, mag;
        logic [7:0] v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                g[i][j] = gray_of(img[(r + i) * W + c + j]);
        gx = (g[0][2] + 2 * g[1][2] + g[2][2]) - (g[0][0] + 2 * g[1][0] + g[2][0]);
        gy = (g[2][0] + 2 * g[2][1] + g[2][2]) - (g[0][0] + 2 * g[0][1] + g[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        v = 8'(255 - mag);
        return {8'h00, v, v, v};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'(IN_B) && a < 32'(IN_B + W * H))
            return img[a - 32'(IN_B)];
        return 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory: responds mem_delay cycles after an address change ----------------
    always @(negedge clk) begin
        if (!n_rst) begin
            hready     = 1'b0;
            last_addr  = '0;
            last_write = 1'b0;
            cnt        = 0;
        end else if (haddr !== last_addr || hwrite !== last_write) begin
            last_addr  = haddr;
            last_write = hwrite;
            cap_data   = hwdata;
            cnt        = mem_delay;
            hready     = 1'b0;
        end else if (hready) begin
            hready = 1'b0;
        end else if (cnt > 0) begin
            if (hwrite && hwdata !== cap_data) stab_err++;
            cnt--;
            if (cnt == 0 && haddr != 0) begin
                hready = 1'b1;
                if (hwrite) begin
                    wr_addr_q.push_back(haddr);
                    wr_data_q.push_back(hwdata);
                end else begin
                    hrdata = mem_word(haddr);
                    rd_addr_q.push_back(haddr);
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic run_frame(input int budget, output bit timed_out);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        stab_err = 0;
        @(negedge clk);
        stop = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic halt();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        stop  = 1'b1;
        #3;
        checks++; if (haddr !== 32'h0)  begin errors++; $display("FAIL reset_haddr: got %h expected 0", haddr); end
        checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h expected 0", hwdata); end
        checks++; if (hwrite !== 1'b0)  begin errors++; $display("FAIL reset_hwrite: got %b expected 0", hwrite); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (haddr !== 32'h0 || hwrite !== 1'b0) begin
            errors++; $display("FAIL idle_with_stop: haddr %h hwrite %b expected 0/0", haddr, hwrite);
        end
    endtask

    task automatic test_random_frame();
        bit to;
        bit f1, fw, fw1;
        int bad;
        mem_delay = 1;
        for (int i = 0; i < W * H; i++) img[i] = $urandom();
        run_frame(4000, to);
        checks++; if (to) begin errors++; $display("FAIL rand_timeout: done never rose"); end
        checks++; if (wr_addr_q.size() != NWR) begin
            errors++; $display("FAIL rand_wr_count: got %0d expected %0d", wr_addr_q.size(), NWR);
        end
        for (int i = 0; i < wr_addr_q.size() && i < NWR; i++) begin
            ref_data[i] = expect_pix(i / OW, i % OW);
            checks++; if (wr_addr_q[i] !== 32'(OUT_B + i)) begin
                errors++; $display("FAIL rand_wr_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], OUT_B + i);
            end
            checks++; if (wr_data_q[i] !== ref_data[i]) begin
                errors++; $display("FAIL rand_wr_data[%0d]: got %h expected %h", i, wr_data_q[i], ref_data[i]);
            end
        end
        checks++; if (rd_addr_q.size() != NRD) begin
            errors++; $display("FAIL rand_rd_count: got %0d expected %0d", rd_addr_q.size(), NRD);
        end
        checks++; if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 32'(IN_B)) begin
            errors++; $display("FAIL first_read: got %0d expected %0d", rd_addr_q.size() ? rd_addr_q[0] : 0, IN_B);
        end
        f1 = 0; fw = 0; fw1 = 0;
        for (int i = 0; i < 9 && i < rd_addr_q.size(); i++) begin
            if (rd_addr_q[i] == 32'(IN_B + 1))     f1 = 1;
            if (rd_addr_q[i] == 32'(IN_B + W))     fw = 1;
            if (rd_addr_q[i] == 32'(IN_B + W + 1)) fw1 = 1;
        end
        checks++; if (!(f1 && fw && fw1)) begin
            errors++; $display("FAIL first_window_reads: found %b%b%b expected 111", f1, fw, fw1);
        end
        bad = 0;
        for (int i = 0; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] == 0 || (i > 0 && rd_addr_q[i] == rd_addr_q[i-1])) bad++;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL read_sequence: got %0d zero/repeated reads expected 0", bad);
        end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1 || hwrite !== 1'b0) begin
            errors++; $display("FAIL done_hold: done %b hwrite %b expected 1/0", done, hwrite);
        end
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin
            errors++; $display("FAIL done_clear_on_stop: got %b expected 0", done);
        end
        @(negedge clk);
    endtask

    task automatic test_delayed_hready();
        bit to;
        mem_delay = 5;
        run_frame(8000, to);
        checks++; if (to) begin errors++; $display("FAIL delay_timeout: done never rose"); end
        checks++; if (stab_err != 0) begin
            errors++; $display("FAIL delay_stability: got %0d hwdata changes expected 0", stab_err);
        end
        checks++; if (wr_addr_q.size() != NWR) begin
            errors++; $display("FAIL delay_wr_count: got %0d expected %0d", wr_addr_q.size(), NWR);
        end
        for (int i = 0; i < wr_addr_q.size() && i < NWR; i++) begin
            checks++; if (wr_addr_q[i] !== 32'(OUT_B + i) || wr_data_q[i] !== ref_data[i]) begin
                errors++; $display("FAIL delay_wr[%0d]: got %0d/%h expected %0d/%h",
                                   i, wr_addr_q[i], wr_data_q[i], OUT_B + i, ref_data[i]);
            end
        end
        halt();
        mem_delay = 1;
    endtask

    task automatic test_uniform();
        bit to;
        for (int i = 0; i < W * H; i++) img[i] = 32'h8080_8080;
        run_frame(4000, to);
        checks++; if (to || wr_data_q.size() != NWR) begin
            errors++; $display("FAIL uniform_frame: timeout %b writes %0d expected 0/%0d", to, wr_data_q.size(), NWR);
        end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            checks++; if (wr_data_q[i] !== 32'h00FF_FFFF) begin
                errors++; $display("FAIL uniform_data[%0d]: got %h expected 00ffffff", i, wr_data_q[i]);
            end
        end
        halt();
    endtask

    task automatic test_vertical_step();
        bit to;
        logic [31:0] e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r * W + c] = (c < STEP) ? {24'h000000, 8'($urandom())}
                                            : {24'hFFFFFF, 8'($urandom())};
        run_frame(4000, to);
        checks++; if (to || wr_data_q.size() != NWR) begin
            errors++; $display("FAIL step_frame: timeout %b writes %0d expected 0/%0d", to, wr_data_q.size(), NWR);
        end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            e = ((i % OW) == STEP - 2 || (i % OW) == STEP - 1) ? 32'h0000_0000 : 32'h00FF_FFFF;
            checks++; if (wr_data_q[i] !== e) begin
                errors++; $display("FAIL step_data[%0d]: got %h expected %h", i, wr_data_q[i], e);
            end
        end
        halt();
    endtask

    task automatic test_stop_restart();
        bit to;
        bit reached;
        mem_delay = 1;
        for (int i = 0; i < W * H; i++) img[i] = $urandom();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        @(negedge clk);
        stop = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_addr_q.size() >= 3 && hwrite) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("FAIL stop_mid_row_wait: no write seen"); end
        stop = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (hwrite !== 1'b0 || done !== 1'b0 || haddr !== 32'h0) begin
            errors++; $display("FAIL stop_abort: hwrite %b done %b haddr %h expected 0/0/0", hwrite, done, haddr);
        end
        repeat (3) @(negedge clk);
        run_frame(4000, to);
        checks++; if (to) begin errors++; $display("FAIL restart_timeout: done never rose"); end
        checks++; if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 32'(IN_B)) begin
            errors++; $display("FAIL restart_first_read: got %0d expected %0d", rd_addr_q.size() ? rd_addr_q[0] : 0, IN_B);
        end
        checks++; if (wr_addr_q.size() != NWR) begin
            errors++; $display("FAIL restart_wr_count: got %0d expected %0d", wr_addr_q.size(), NWR);
        end
        for (int i = 0; i < wr_addr_q.size() && i < NWR; i++) begin
            checks++; if (wr_addr_q[i] !== 32'(OUT_B + i) || wr_data_q[i] !== expect_pix(i / OW, i % OW)) begin
                errors++; $display("FAIL restart_wr[%0d]: got %0d/%h expected %0d/%h",
                                   i, wr_addr_q[i], wr_data_q[i], OUT_B + i, expect_pix(i / OW, i % OW));
            end
        end
        halt();
    endtask

    task automatic test_async_reset();
        bit to;
        bit reached;
        mem_delay = 5;
        @(negedge clk);
        stop = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (hwrite) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("FAIL async_wait_write: no write seen"); end
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checks++; if (haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_reset: haddr %h hwdata %h hwrite %b done %b expected all 0",
                               haddr, hwdata, hwrite, done);
        end
        stop = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        mem_delay = 1;
        run_frame(4000, to);
        checks++; if (to || wr_data_q.size() != NWR) begin
            errors++; $display("FAIL post_reset_frame: timeout %b writes %0d expected 0/%0d", to, wr_data_q.size(), NWR);
        end
        for (int i = 0; i < wr_data_q.size() && i < NWR; i++) begin
            checks++; if (wr_data_q[i] !== expect_pix(i / OW, i % OW)) begin
                errors++; $display("FAIL post_reset_data[%0d]: got %h expected %h", i, wr_data_q[i], expect_pix(i / OW, i % OW));
            end
        end
        halt();
    endtask

    initial begin
        test_reset();
        test_random_frame();
        test_delayed_hready();
        test_uniform();
        test_vertical_step();
        test_stop_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
